// File: rtl/regfile_pkg.sv
// Shared constants and the queued write-back entry for the register file
// write side.
package regfile_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push / single-pop circular buffer of write-back entries. Exposes its
// storage so the owner can run lookups over the queued entries.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     ctrl_reset_n,
    input  logic                     push0,
    input  wb_entry_t                ent0,
    input  logic                     push1,
    input  wb_entry_t                ent1,
    input  logic                     pop,
    output wb_entry_t                entries [DEPTH],
    output logic [DEPTH-1:0]         valid,
    output logic [$clog2(DEPTH)-1:0] head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] slot1;
    logic [PTR_W-1:0] off;
    logic             pop_ok;

    // push0 is always the older entry; push1 lands right behind it
    always_comb begin
        mem_d   = mem_q;
        pop_ok  = pop && (count_q != '0);
        slot1   = tail_q + PTR_W'(push0);
        if (push0) mem_d[tail_q] = ent0;
        if (push1) mem_d[slot1]  = ent1;
        tail_d  = tail_q + PTR_W'(push0) + PTR_W'(push1);
        head_d  = head_q + PTR_W'(pop_ok);
        count_d = count_q + CNT_W'(push0) + CNT_W'(push1)
                - CNT_W'(pop_ok);
    end

    always_comb begin
        off   = '0;
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PTR_W'(i) - head_q;
            valid[i] = CNT_W'(off) < count_q;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign entries = mem_q;
    assign head    = head_q;
    assign count   = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Write-side master for the register file: merges multdiv and ALU results
// into one in-order queue, retires one write per cycle, offers bypass lookup.
module regfile_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int REG_W  = regfile_pkg::REG_W
) (
    input  logic                   clock,
    input  logic                   ctrl_reset_n,
    input  logic                   md_valid,
    input  logic [REG_W-1:0]       md_rd,
    input  logic [DATA_W-1:0]      md_data,
    output logic                   md_ready,
    input  logic                   alu_valid,
    input  logic [REG_W-1:0]       alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    output logic                   ctrl_writeEnable,
    output logic [REG_W-1:0]       ctrl_writeReg,
    output logic [DATA_W-1:0]      data_writeReg,
    input  logic [REG_W-1:0]       chk_regA,
    input  logic [REG_W-1:0]       chk_regB,
    output logic                   hitA,
    output logic                   hitB,
    output logic [DATA_W-1:0]      fwd_dataA,
    output logic [DATA_W-1:0]      fwd_dataB,
    output logic [$clog2(DEPTH):0] count
);

    import regfile_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        entries [DEPTH];
    wb_entry_t        ent0, ent1, head_ent;
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] idx;
    logic [CNT_W-1:0] free;
    logic             push0, push1, pop;

    // head slot frees up on this edge, so it counts toward capacity
    assign pop       = (count != '0);
    assign free      = CNT_W'(DEPTH) - count + CNT_W'(pop);
    assign md_ready  = (free >= CNT_W'(1));
    assign alu_ready = (free >= CNT_W'(2));

    assign push0 = md_valid && md_ready && (md_rd != '0);
    assign push1 = alu_valid && alu_ready && (alu_rd != '0);

    assign ent0 = '{rd: md_rd, data: md_data};
    assign ent1 = '{rd: alu_rd, data: alu_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .push0        (push0),
        .ent0         (ent0),
        .push1        (push1),
        .ent1         (ent1),
        .pop          (pop),
        .entries      (entries),
        .valid        (valid),
        .head         (head),
        .count        (count)
    );

    assign head_ent         = entries[head];
    assign ctrl_writeEnable = pop;
    assign ctrl_writeReg    = pop ? head_ent.rd : '0;
    assign data_writeReg    = pop ? head_ent.data : '0;

    // walk oldest to youngest so the youngest match is the one left standing
    always_comb begin
        idx       = '0;
        hitA      = 1'b0;
        hitB      = 1'b0;
        fwd_dataA = '0;
        fwd_dataB = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && chk_regA != '0
                && entries[idx].rd == chk_regA) begin
                hitA      = 1'b1;
                fwd_dataA = entries[idx].data;
            end
            if (valid[idx] && chk_regB != '0
                && entries[idx].rd == chk_regB) begin
                hitB      = 1'b1;
                fwd_dataB = entries[idx].data;
            end
        end
    end

endmodule
